// File: rtl/div_pkg.sv
// Shared definitions for the divider tick decoder: lock FSM states, default
// sizes and the tap-clamping helper.
package div_pkg;

    localparam int DEF_WIDTH       = 15;
    localparam int DEF_LOCK_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_FAULT    = 2'd3
    } lock_state_t;

    // Out-of-range selects clamp to the MSB of the count.
    function automatic int eff_tap(input logic [3:0] sel, input int width);
        return (int'(sel) > width - 1) ? width - 1 : int'(sel);
    endfunction

endpackage

// File: rtl/div_tick_decoder_if.sv
// Signal bundle between a divider count source and the tick decoder.
interface div_tick_decoder_if #(
    parameter int WIDTH = div_pkg::DEF_WIDTH
);
    logic [WIDTH-1:0] count_in;
    logic [3:0]       tap_sel;
    logic             clr_err;
    logic             tick;
    logic             wrap;
    logic             locked;
    logic             err;
    logic [7:0]       tick_cnt;

    modport master (
        output count_in, tap_sel, clr_err,
        input  tick, wrap, locked, err, tick_cnt
    );

    modport slave (
        input  count_in, tap_sel, clr_err,
        output tick, wrap, locked, err, tick_cnt
    );
endinterface

// File: rtl/div_tick_decoder_tap_edge_detect.sv
// Tap mux plus rising-edge detector; a tap_sel change suppresses the tick for
// that cycle so a mux switch is never mistaken for a count edge.
module tap_edge_detect
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic [3:0]       tap_sel,
    input  logic             arm,
    output logic             tick
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [IDX_W-1:0] tap_idx;
    logic             tap_bit;
    logic             prev_tap;
    logic [3:0]       prev_sel;

    assign tap_idx = IDX_W'(eff_tap(tap_sel, WIDTH));
    assign tap_bit = count_in[tap_idx];

    // NOTE: every register here is state, so it uses non-blocking assignment and the async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_tap <= 1'b0;
            prev_sel <= 4'd0;
            tick     <= 1'b0;
        end else begin
            prev_tap <= tap_bit;
            prev_sel <= tap_sel;
            tick     <= arm && tap_bit && !prev_tap && (tap_sel == prev_sel);
        end
    end

endmodule

// File: rtl/div_tick_decoder.sv
// Decodes a free-running divider count: verifies +1 continuity with a lock
// FSM, emits tap ticks and wrap pulses, and counts issued ticks.
module div_tick_decoder
    import div_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input logic               clk,
    input logic               reset,
    div_tick_decoder_if.slave bus
);
    localparam int RUN_W = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CYCLES);

    lock_state_t      state;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic [WIDTH-1:0] prev_count;
    logic [WIDTH-1:0] expected;
    logic             step_ok;
    logic             tick;
    logic             wrap;
    logic             locked;
    logic             err;
    logic [7:0]       tick_cnt;

    assign expected = prev_count + 1'b1;
    assign step_ok  = (bus.count_in == expected);
    assign run_inc  = (run == RUN_MAX) ? run : run + 1'b1;

    tap_edge_detect #(.WIDTH(WIDTH)) u_tap (
        .clk      (clk),
        .reset    (reset),
        .count_in (bus.count_in),
        .tap_sel  (bus.tap_sel),
        .arm      (state == ST_LOCKED),
        .tick     (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_UNLOCKED;
            run        <= '0;
            prev_count <= '0;
            wrap       <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            tick_cnt   <= 8'd0;
        end else begin
            prev_count <= bus.count_in;
            wrap       <= (prev_count == '1) && (bus.count_in == '0);
            if (tick) tick_cnt <= tick_cnt + 1'b1;

            // clr_err outranks every FSM transition, including FAULT entry.
            if (bus.clr_err) begin
                state  <= ST_UNLOCKED;
                run    <= '0;
                locked <= 1'b0;
                err    <= 1'b0;
            end else begin
                case (state)
                    ST_UNLOCKED: begin
                        state <= ST_LOCKING;
                        run   <= '0;
                    end
                    ST_LOCKING: begin
                        if (step_ok) begin
                            run <= run_inc;
                            if (run_inc == RUN_MAX) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (!step_ok) begin
                            state  <= ST_FAULT;
                            locked <= 1'b0;
                            err    <= 1'b1;
                        end
                    end
                    default: ; // ST_FAULT waits for clr_err
                endcase
            end
        end
    end

    assign bus.tick     = tick;
    assign bus.wrap     = wrap;
    assign bus.locked   = locked;
    assign bus.err      = err;
    assign bus.tick_cnt = tick_cnt;

endmodule
